// File: rtl/clken_gen.sv
// Clock-enable generator: waits for a stable PLL lock, then emits per-channel
// clock-enable strobes and divided square waves with programmable divide and phase.
module clken_gen #(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 16,
  parameter int LOCK_CYC = 1024
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic [NUM_CH*DIV_W-1:0] phase,
  input  logic                    cfg_load,
  input  logic                    lock_lost_clr,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       clk_div,
  output logic                    ready,
  output logic                    lock_lost
);

  localparam logic [19:0]      LOCK_LAST = 20'(LOCK_CYC - 1);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [19:0]                  lock_cnt_q, lock_cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0] div_sh_q, div_sh_d;
  logic [NUM_CH-1:0][DIV_W-1:0] ph_sh_q, ph_sh_d;
  logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            ce_q, ce_d;
  logic [NUM_CH-1:0]            clk_div_q, clk_div_d;
  logic                         ready_q, ready_d;
  logic                         lock_lost_q, lock_lost_d;
  logic                         enter_run, lock_drop, run_next, reload;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    enter_run  = 1'b0;
    lock_drop  = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (!pll_locked) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          enter_run  = 1'b1;
          state_d    = RUN;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 20'd1;
        end
      end
      RUN: begin
        lock_cnt_d = '0;
        if (!pll_locked) begin
          lock_drop = 1'b1;
          state_d   = WAIT_LOCK;
        end
      end
    endcase

    run_next = (state_d == RUN);
    // Counters realign on RUN entry and on any configuration load while running.
    reload   = enter_run || ((state_q == RUN) && cfg_load);
    ready_d  = run_next;

    lock_lost_d = lock_lost_q;
    if (lock_lost_clr) lock_lost_d = 1'b0;
    if (lock_drop)     lock_lost_d = 1'b1;

    div_sh_d = cfg_load ? div_ratio : div_sh_q;
    ph_sh_d  = cfg_load ? phase     : ph_sh_q;
  end

  // A load in the same cycle uses the incoming values, so the *_sh_d view is the live config.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] d_eff, p_eff, d_last, p_load, cnt_run;
    logic             slow;

    assign d_eff   = div_sh_d[gi];
    assign p_eff   = ph_sh_d[gi];
    assign slow    = (d_eff > ONE);
    assign d_last  = d_eff - ONE;
    assign p_load  = (p_eff >= d_eff) ? '0 : p_eff;
    assign cnt_run = (!slow || (cnt_q[gi] >= d_last)) ? '0 : (cnt_q[gi] + ONE);

    assign cnt_d[gi]     = !run_next ? '0 : (reload ? p_load : cnt_run);
    assign ce_d[gi]      = run_next && (!slow || (cnt_d[gi] == d_last));
    assign clk_div_d[gi] = run_next && slow && (cnt_d[gi] < (d_eff >> 1));
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q     <= WAIT_LOCK;
      lock_cnt_q  <= '0;
      div_sh_q    <= '0;
      ph_sh_q     <= '0;
      cnt_q       <= '0;
      ce_q        <= '0;
      clk_div_q   <= '0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      div_sh_q    <= div_sh_d;
      ph_sh_q     <= ph_sh_d;
      cnt_q       <= cnt_d;
      ce_q        <= ce_d;
      clk_div_q   <= clk_div_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign ce        = ce_q;
  assign clk_div   = clk_div_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_clken_gen.sv
// Directed self-checking bench for clken_gen: lock timing, divide/phase traces,
// realignment, lock loss handling and mid-run reset.
module tb_clken_gen;

  localparam int NUM_CH   = 2;
  localparam int DIV_W    = 8;
  localparam int LOCK_CYC = 16;

  logic                    refclk = 1'b0;
  logic                    rst;
  logic                    pll_locked;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic [NUM_CH*DIV_W-1:0] phase;
  logic                    cfg_load;
  logic                    lock_lost_clr;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       clk_div;
  logic                    ready;
  logic                    lock_lost;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ce[$];
  int exp_clk[$];

  clken_gen #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .LOCK_CYC(LOCK_CYC)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .div_ratio    (div_ratio),
    .phase        (phase),
    .cfg_load     (cfg_load),
    .lock_lost_clr(lock_lost_clr),
    .ce           (ce),
    .clk_div      (clk_div),
    .ready        (ready),
    .lock_lost    (lock_lost)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge; return on the falling edge where outputs are stable.
  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input int d0, input int p0, input int d1, input int p1);
    div_ratio = {8'(d1), 8'(d0)};
    phase     = {8'(p1), 8'(p0)};
  endtask

  task automatic load_cfg();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_ce"}, 32'(ce), 32'd0);
    check({tag, "_clkdiv"}, 32'(clk_div), 32'd0);
  endtask

  task automatic run_trace(input string tag);
    for (int i = 0; i < exp_ce.size(); i++) begin
      check($sformatf("%s_ce_t%0d", tag, i), 32'(ce), 32'(exp_ce[i]));
      check($sformatf("%s_clk_t%0d", tag, i), 32'(clk_div), 32'(exp_clk[i]));
      tick();
    end
  endtask

  // Wait LOCK_CYC-1 edges expecting no ready, then one more expecting ready.
  task automatic lock_wait(input string tag);
    ticks(LOCK_CYC - 1);
    check({tag, "_early"}, 32'(ready), 32'd0);
    tick();
    check({tag, "_rise"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b0;
    pll_locked    = 1'b0;
    cfg_load      = 1'b0;
    lock_lost_clr = 1'b0;
    set_cfg(0, 0, 0, 0);
    ticks(3);
    check_idle("reset");
    check("reset_lost", 32'(lock_lost), 32'd0);

    rst = 1'b1;
    set_cfg(5, 0, 4, 2);
    load_cfg();
    check_idle("cfg_in_wait");

    // Lock glitch on the 11th locked cycle restarts the count.
    pll_locked = 1'b1;
    ticks(10);
    pll_locked = 1'b0;
    tick();
    check("glitch_ready", 32'(ready), 32'd0);
    pll_locked = 1'b1;
    lock_wait("relock");

    // D=5 P=0 on ch0, D=4 P=2 on ch1 from RUN entry.
    exp_ce  = '{0, 2, 0, 0, 1, 2, 0, 0, 0, 3};
    exp_clk = '{1, 1, 2, 2, 0, 1, 3, 2, 0, 0};
    run_trace("entry");

    // Mid-run load of D=4 on both, P={0,2}: realigned next cycle.
    set_cfg(4, 0, 4, 2);
    load_cfg();
    exp_ce  = '{0, 2, 0, 1, 0, 2, 0, 1};
    exp_clk = '{1, 1, 2, 2, 1, 1, 2, 2};
    run_trace("realign");

    set_cfg(1, 3, 0, 0);
    load_cfg();
    exp_ce  = '{3, 3, 3, 3};
    exp_clk = '{0, 0, 0, 0};
    run_trace("d01");

    // P=7 >= D=4 loads as 0.
    set_cfg(4, 7, 4, 0);
    load_cfg();
    exp_ce  = '{0, 0, 0, 3};
    exp_clk = '{3, 3, 0, 0};
    run_trace("p_ge_d");

    pll_locked = 1'b0;
    tick();
    check_idle("loss");
    check("loss_lost", 32'(lock_lost), 32'd1);
    lock_lost_clr = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    check("clr_lost", 32'(lock_lost), 32'd0);

    pll_locked = 1'b1;
    lock_wait("lock2");

    // Loss with simultaneous clear and config load.
    pll_locked    = 1'b0;
    lock_lost_clr = 1'b1;
    set_cfg(3, 1, 6, 0);
    cfg_load      = 1'b1;
    tick();
    lock_lost_clr = 1'b0;
    cfg_load      = 1'b0;
    check_idle("loss_clr");
    check("loss_clr_lost", 32'(lock_lost), 32'd1);

    pll_locked = 1'b1;
    lock_wait("lock3");
    exp_ce  = '{0, 1, 0, 0, 1, 2};
    exp_clk = '{2, 2, 3, 0, 0, 1};
    run_trace("newcfg");

    rst = 1'b0;
    tick();
    check_idle("midrst");
    check("midrst_lost", 32'(lock_lost), 32'd0);
    rst = 1'b1;
    lock_wait("lock4");
    // Shadow config was cleared by reset: D=0 on both channels.
    check("zero_cfg_ce", 32'(ce), 32'd3);
    check("zero_cfg_clk", 32'(clk_div), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clken_gen.md
CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 Parameter NUM_CH, default 2: number of output channels, range 1..8.
REQ-002 Parameter DIV_W, default 16: width of each channel's divide and phase fields.
REQ-003 Parameter LOCK_CYC, default 1024: consecutive locked cycles required before RUN, range 1..2^20.
REQ-004 refclk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 pll_locked  in  1  upstream PLL lock status, already synchronous to refclk.
REQ-007 div_ratio  in  NUM_CH*DIV_W  per-channel divide D; channel k occupies bits [k*DIV_W +: DIV_W].
REQ-008 phase  in  NUM_CH*DIV_W  per-channel start offset P, packed like div_ratio.
REQ-009 cfg_load  in  1  single-cycle strobe that captures div_ratio and phase into shadow registers.
REQ-010 lock_lost_clr  in  1  clears the sticky lock_lost flag.
REQ-011 ce  out  NUM_CH  per-channel one-cycle clock-enable strobe.
REQ-012 clk_div  out  NUM_CH  per-channel divided square wave, registered.
REQ-013 ready  out  1  high only in RUN.
REQ-014 lock_lost  out  1  sticky flag, set on lock loss while in RUN.

Function
REQ-015 The block SHALL implement states WAIT_LOCK and RUN; after reset it SHALL be in WAIT_LOCK.
REQ-016 In WAIT_LOCK, a 20-bit counter SHALL increment each cycle pll_locked=1 and clear to 0 on any cycle pll_locked=0.
REQ-017 WAIT_LOCK SHALL go to RUN on the cycle the counter reaches LOCK_CYC-1 with pll_locked=1, so ready rises exactly LOCK_CYC cycles after pll_locked becomes stable high.
REQ-018 In RUN, pll_locked=0 SHALL cause:
- next state WAIT_LOCK;
- lock counter cleared;
- ready, ce and clk_div driven 0 from the next cycle;
- lock_lost set.
REQ-019 Outside RUN, ce and clk_div SHALL be all-zero.
REQ-020 Channel counters SHALL be DIV_W bits wide.
REQ-021 On entry to RUN and on every cfg_load accepted in RUN, all channel counters SHALL load their P simultaneously; channels are then phase-realigned.
REQ-022 If P >= D, that channel SHALL load 0 instead of P.
REQ-023 For D >= 2, the counter SHALL count 0..D-1 and wrap to 0.
REQ-024 For D >= 2, ce[k] SHALL be 1 exactly on cycles where counter == D-1, giving a period of D cycles.
REQ-025 For D >= 2, clk_div[k] SHALL be 1 when counter < floor(D/2), else 0; odd D gives a high time one cycle shorter than the low time.
REQ-026 For D in {0,1}, ce[k] SHALL be 1 every RUN cycle and clk_div[k] SHALL be 0.
REQ-027 First ce after a counter load SHALL occur D-1-P cycles later, or on the same cycle if P = D-1.
REQ-028 Shadow registers SHALL update on cfg_load in any state; a load in WAIT_LOCK takes effect on RUN entry.
REQ-029 On simultaneous cfg_load and lock loss, the shadow registers SHALL update, and lock loss SHALL take precedence for state and outputs.
REQ-030 On simultaneous lock_lost set and lock_lost_clr, set SHALL win.
REQ-031 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-032 While rst=0 at a rising edge, the block SHALL take these values:
- state WAIT_LOCK;
- lock counter 0;
- channel counters 0;
- ce=0, clk_div=0, ready=0, lock_lost=0;
- shadow D=0 and P=0.
REQ-033 Reset SHALL take precedence over all other inputs, including in the middle of RUN.

Verification
REQ-034 LOCK_CYC=16, pll_locked high from cycle 0 -> ready=1 at cycle 16; pll_locked dropped at cycle 10 then re-raised at cycle 11 -> ready=1 at cycle 27.
REQ-035 D=5, P=0 -> ce pulses every 5 cycles, first pulse 4 cycles after RUN entry; clk_div high 2 cycles, low 3 cycles.
REQ-036 Two channels with D=4 and P={0,2} -> channel 1 ce leads channel 0 ce by 2 cycles; a cfg_load of the same values mid-run realigns both on the next cycle.
REQ-037 D=1 and D=0 -> ce constantly 1 and clk_div 0; P=7 with D=4 -> behaves as P=0.
REQ-038 Lock loss in RUN -> ready, ce and clk_div are 0 the next cycle and lock_lost=1; lock_lost_clr asserted together with a fresh loss -> lock_lost stays 1.
REQ-039 rst=0 asserted mid-RUN -> all outputs 0 the following cycle, and the lock sequence restarts from count 0.
